// File: rtl/spell_dbg_pkg.sv
// Shared types and constants for the SPELL serial debug port.
// Register-select codes follow the core's debug register map.
package spell_dbg_pkg;

    localparam int DBG_WIDTH = 8;
    localparam int DBG_SEL_W = 2;

    localparam logic [DBG_SEL_W-1:0] REG_PC        = 2'd0;
    localparam logic [DBG_SEL_W-1:0] REG_SP        = 2'd1;
    localparam logic [DBG_SEL_W-1:0] REG_EXEC      = 2'd2;
    localparam logic [DBG_SEL_W-1:0] REG_STACK_TOP = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_WR,
        ST_RD_ADDR,
        ST_RD_CAP
    } dbg_state_t;

endpackage

// File: rtl/spell_dbg_sync.sv
// Per-pin synchroniser (STAGES flops, 0 = pass-through) with an optional rising-edge detector.
// With EDGE set, q is a one-cycle pulse per 0->1 transition; otherwise q is the synchronised level.
module spell_dbg_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2,
    parameter bit EDGE   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] synced;

    if (STAGES == 0) begin : g_direct
        assign synced = pin;
    end else begin : g_chain
        logic [WIDTH-1:0] chain [STAGES];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < STAGES; i++) begin
                    chain[i] <= '0;
                end
            end else begin
                chain[0] <= pin;
                for (int i = 1; i < STAGES; i++) begin
                    chain[i] <= chain[i-1];
                end
            end
        end

        assign synced = chain[STAGES-1];
    end

    if (EDGE) begin : g_edge
        // Edges are suppressed until the chain has refilled after reset, so a pin
        // held high through reset release is not mistaken for a fresh rising edge.
        localparam int SETTLE = STAGES + 1;
        localparam int CW     = $clog2(SETTLE + 1);

        logic [CW-1:0]    settle_cnt;
        logic [WIDTH-1:0] prev;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                settle_cnt <= '0;
                prev       <= '0;
            end else begin
                prev <= synced;
                if (settle_cnt != CW'(SETTLE)) begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
            end
        end

        assign q = (settle_cnt == CW'(SETTLE)) ? (synced & ~prev) : '0;
    end else begin : g_level
        assign q = synced;
    end

endmodule

// File: rtl/spell_dbg_port.sv
// spell_dbg_port: serial debug front-end between the ui_in debug pins and the SPELL core.
// Define SPELL_DBG_SYNC_EN to pass every debug pin through a SYNC_STAGES-deep synchroniser.
module spell_dbg_port
    import spell_dbg_pkg::*;
#(
    parameter int WIDTH       = DBG_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_dump,
    input  logic             i_shift_in,
    input  logic [1:0]       i_reg_sel,
    input  logic             i_cpu_stopped,
    input  logic [WIDTH-1:0] i_reg_rd_data,
    output logic [1:0]       o_reg_rd_sel,
    output logic             o_reg_wr,
    output logic [1:0]       o_reg_wr_sel,
    output logic [WIDTH-1:0] o_reg_wr_data,
    output logic             o_shift_out,
    output logic             o_busy
);

    dbg_state_t state, next_state;

    logic             load_p;
    logic             dump_p;
    logic             shift_bit;
    logic [1:0]       sel_pin;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] wr_data;
    logic [1:0]       wr_sel;
    logic [1:0]       rd_sel;

`ifdef SPELL_DBG_SYNC_EN
    localparam int PIN_STAGES = SYNC_STAGES;

    spell_dbg_sync #(.WIDTH(1), .STAGES(PIN_STAGES), .EDGE(1'b0)) u_shift_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (i_shift_in),
        .q     (shift_bit)
    );

    spell_dbg_sync #(.WIDTH(2), .STAGES(PIN_STAGES), .EDGE(1'b0)) u_sel_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (i_reg_sel),
        .q     (sel_pin)
    );
`else
    localparam int PIN_STAGES = 0;

    assign shift_bit = i_shift_in;
    assign sel_pin   = i_reg_sel;
`endif

    spell_dbg_sync #(.WIDTH(1), .STAGES(PIN_STAGES), .EDGE(1'b1)) u_load_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (i_load),
        .q     (load_p)
    );

    spell_dbg_sync #(.WIDTH(1), .STAGES(PIN_STAGES), .EDGE(1'b1)) u_dump_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (i_dump),
        .q     (dump_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Load has priority over dump; pulses seen outside IDLE are dropped, not queued.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (load_p) begin
                    next_state = i_cpu_stopped ? ST_WR : ST_WR_WAIT;
                end else if (dump_p) begin
                    next_state = ST_RD_ADDR;
                end
            end
            ST_WR_WAIT: begin
                if (i_cpu_stopped) begin
                    next_state = ST_WR;
                end
            end
            ST_WR:      next_state = ST_IDLE;
            ST_RD_ADDR: next_state = ST_RD_CAP;
            ST_RD_CAP:  next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_reg_wr = 1'b0;
        o_busy   = 1'b1;
        case (state)
            ST_IDLE: o_busy   = 1'b0;
            ST_WR:   o_reg_wr = 1'b1;
            default: ;
        endcase
    end

    // The write payload is the shift register as it stood before this cycle's shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            wr_sel  <= '0;
            wr_data <= '0;
            rd_sel  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_WR_WAIT: sr <= {sr[WIDTH-2:0], shift_bit};
                ST_RD_CAP:           sr <= i_reg_rd_data;
                default: ;
            endcase
            if (state == ST_IDLE) begin
                if (load_p) begin
                    wr_sel  <= sel_pin;
                    wr_data <= sr;
                end else if (dump_p) begin
                    rd_sel <= sel_pin;
                end
            end
        end
    end

    assign o_reg_rd_sel  = rd_sel;
    assign o_reg_wr_sel  = wr_sel;
    assign o_reg_wr_data = wr_data;
    assign o_shift_out   = sr[WIDTH-1];

endmodule

// File: tb/tb_spell_dbg_port.sv
// Bench for spell_dbg_port (default build): directed vector table, hand-written corner
// sequences and randomized pin traffic, all checked against a transaction-level model.
module tb_spell_dbg_port;
    import spell_dbg_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic       dump;
    logic       shift_in;
    logic [1:0] reg_sel;
    logic       cpu_stopped;
    logic [7:0] rd_data;
    logic [1:0] rd_sel;
    logic       reg_wr;
    logic [1:0] wr_sel;
    logic [7:0] wr_data;
    logic       shift_out;
    logic       busy;

    logic [7:0] core_regs [4];

    int n_compared = 0;
    int n_failed   = 0;

    spell_dbg_port dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (load),
        .i_dump        (dump),
        .i_shift_in    (shift_in),
        .i_reg_sel     (reg_sel),
        .i_cpu_stopped (cpu_stopped),
        .i_reg_rd_data (rd_data),
        .o_reg_rd_sel  (rd_sel),
        .o_reg_wr      (reg_wr),
        .o_reg_wr_sel  (wr_sel),
        .o_reg_wr_data (wr_data),
        .o_shift_out   (shift_out),
        .o_busy        (busy)
    );

    // The core answers a read select with that register's contents.
    assign rd_data = core_regs[rd_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one pending transaction at a time, described by what it is still waiting for.
    logic [7:0] m_sr;
    logic [7:0] m_wdata;
    logic [1:0] m_wsel;
    logic [1:0] m_rsel;
    bit         m_wait_stop;
    bit         m_strobe;
    int         m_rd_left;
    bit         m_prev_load;
    bit         m_prev_dump;
    bit         m_primed;

    task automatic model_reset();
        m_sr        = '0;
        m_wdata     = '0;
        m_wsel      = '0;
        m_rsel      = '0;
        m_wait_stop = 0;
        m_strobe    = 0;
        m_rd_left   = 0;
        m_prev_load = 0;
        m_prev_dump = 0;
        m_primed    = 0;
    endtask

    task automatic model_edge();
        bit lp, dp, idle;
        logic [7:0] old_sr;
        lp = m_primed && load && !m_prev_load;
        dp = m_primed && dump && !m_prev_dump;
        m_prev_load = load;
        m_prev_dump = dump;
        m_primed    = 1;
        idle   = !m_wait_stop && !m_strobe && (m_rd_left == 0);
        old_sr = m_sr;
        if (m_rd_left == 1)
            m_sr = core_regs[m_rsel];
        else if (idle || m_wait_stop)
            m_sr = {old_sr[6:0], shift_in};
        if (idle) begin
            if (lp) begin
                m_wsel  = reg_sel;
                m_wdata = old_sr;
                if (cpu_stopped) m_strobe = 1;
                else             m_wait_stop = 1;
            end else if (dp) begin
                m_rsel    = reg_sel;
                m_rd_left = 2;
            end
        end else if (m_wait_stop) begin
            if (cpu_stopped) begin
                m_wait_stop = 0;
                m_strobe    = 1;
            end
        end else if (m_strobe) begin
            m_strobe = 0;
        end else begin
            m_rd_left--;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_output();
        bit m_busy;
        m_busy = m_wait_stop || m_strobe || (m_rd_left != 0);
        check("model",
              32'({reg_wr, busy, shift_out, wr_sel, wr_data, rd_sel}),
              32'({m_strobe, m_busy, m_sr[7], m_wsel, m_wdata, m_rsel}));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_output();
    endtask

    task automatic apply_stimulus(input logic l, input logic d, input logic s,
                                  input logic [1:0] sel, input logic st);
        load        = l;
        dump        = d;
        shift_in    = s;
        reg_sel     = sel;
        cpu_stopped = st;
        step();
    endtask

    typedef struct {
        logic       load;
        logic       dump;
        logic       sin;
        logic [1:0] sel;
        logic       stopped;
        logic       exp_wr;
        logic       exp_busy;
        logic       exp_out;
        logic [7:0] exp_wdata;
        logic [1:0] exp_wsel;
    } vec_t;

    function automatic vec_t mk(input logic l, input logic d, input logic s, input logic [1:0] sel,
                                input logic st, input logic ew, input logic eb, input logic eo,
                                input logic [7:0] ewd, input logic [1:0] ews);
        vec_t v;
        v.load = l; v.dump = d; v.sin = s; v.sel = sel; v.stopped = st;
        v.exp_wr = ew; v.exp_busy = eb; v.exp_out = eo; v.exp_wdata = ewd; v.exp_wsel = ews;
        return v;
    endfunction

    vec_t vecs[$];
    logic [7:0] pattern;

    initial begin
        core_regs[0] = 8'h81;
        core_regs[1] = 8'h5A;
        core_regs[2] = 8'hC3;
        core_regs[3] = 8'h7E;

        // Reset with load held high: no write after release, outputs idle.
        rst_n = 1'b0; load = 1'b1; dump = 1'b0; shift_in = 1'b0;
        reg_sel = REG_PC; cpu_stopped = 1'b1;
        model_reset();
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out", 32'(shift_out), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, REG_PC, 1'b1);
            check("held_load_wr", 32'(reg_wr), 32'd0);
            check("held_load_busy", 32'(busy), 32'd0);
            check("held_load_out", 32'(shift_out), 32'd0);
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, REG_PC, 1'b1);

        // Shift A5 MSB-first, load to REG_SP, then dump REG_PC (0x81) and shift it back out.
        // The dump-registering edge is the first row of the dump; the new MSB shows after the third.
        vecs.push_back(mk(0,0,1,REG_SP,1, 0,0,0,8'h00,2'd0));
        vecs.push_back(mk(0,0,0,REG_SP,1, 0,0,0,8'h00,2'd0));
        vecs.push_back(mk(0,0,1,REG_SP,1, 0,0,0,8'h00,2'd0));
        vecs.push_back(mk(0,0,0,REG_SP,1, 0,0,0,8'h00,2'd0));
        vecs.push_back(mk(0,0,0,REG_SP,1, 0,0,0,8'h00,2'd0));
        vecs.push_back(mk(0,0,1,REG_SP,1, 0,0,0,8'h00,2'd0));
        vecs.push_back(mk(0,0,0,REG_SP,1, 0,0,0,8'h00,2'd0));
        vecs.push_back(mk(0,0,1,REG_SP,1, 0,0,1,8'h00,2'd0));
        vecs.push_back(mk(1,0,0,REG_SP,1, 1,1,0,8'hA5,2'd1));
        vecs.push_back(mk(0,0,0,REG_SP,1, 0,0,0,8'hA5,2'd1));
        vecs.push_back(mk(0,0,0,REG_SP,1, 0,0,1,8'hA5,2'd1));
        vecs.push_back(mk(0,1,0,REG_PC,1, 0,1,0,8'hA5,2'd1));
        vecs.push_back(mk(0,0,0,REG_PC,1, 0,1,0,8'hA5,2'd1));
        vecs.push_back(mk(0,0,0,REG_PC,1, 0,0,1,8'hA5,2'd1));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0,0,0,REG_PC,1, 0,0,0,8'hA5,2'd1));
        vecs.push_back(mk(0,0,0,REG_PC,1, 0,0,1,8'hA5,2'd1));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].load, vecs[i].dump, vecs[i].sin, vecs[i].sel, vecs[i].stopped);
            check($sformatf("tbl%0d_wr", i), 32'(reg_wr), 32'(vecs[i].exp_wr));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("tbl%0d_out", i), 32'(shift_out), 32'(vecs[i].exp_out));
            check($sformatf("tbl%0d_wdata", i), 32'(wr_data), 32'(vecs[i].exp_wdata));
            check($sformatf("tbl%0d_wsel", i), 32'(wr_sel), 32'(vecs[i].exp_wsel));
        end

        // Write held while the core runs, released the cycle after it stops.
        pattern = 8'h3C;
        for (int i = 7; i >= 0; i--)
            apply_stimulus(1'b0, 1'b0, pattern[i], REG_EXEC, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, REG_EXEC, 1'b0);
        check("wait_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, REG_EXEC, 1'b0);
            check("wait_no_wr", 32'(reg_wr), 32'd0);
            check("wait_still_busy", 32'(busy), 32'd1);
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, REG_EXEC, 1'b1);
        check("release_wr", 32'(reg_wr), 32'd1);
        check("release_wdata", 32'(wr_data), 32'h3C);
        check("release_wsel", 32'(wr_sel), 32'(REG_EXEC));
        apply_stimulus(1'b0, 1'b0, 1'b0, REG_EXEC, 1'b1);
        check("release_done_wr", 32'(reg_wr), 32'd0);
        check("release_done_busy", 32'(busy), 32'd0);

        // Simultaneous load+dump: load wins; a later dump during WR_WAIT is ignored.
        apply_stimulus(1'b1, 1'b1, 1'b0, REG_STACK_TOP, 1'b0);
        check("both_busy", 32'(busy), 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b0, REG_STACK_TOP, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, REG_EXEC, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, REG_EXEC, 1'b0);
        check("both_no_wr_yet", 32'(reg_wr), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, REG_EXEC, 1'b1);
        check("both_wr", 32'(reg_wr), 32'd1);
        check("both_wsel", 32'(wr_sel), 32'(REG_STACK_TOP));
        apply_stimulus(1'b0, 1'b0, 1'b0, REG_EXEC, 1'b1);
        check("both_idle", 32'(busy), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, REG_EXEC, 1'b1);
        check("both_no_read_busy", 32'(busy), 32'd0);
        check("both_no_read_sel", 32'(rd_sel), 32'(REG_PC));

        // Asynchronous reset while waiting for the core aborts the pending write.
        apply_stimulus(1'b1, 1'b0, 1'b1, REG_SP, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, REG_SP, 1'b0);
        check("abort_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wdata", 32'(wr_data), 32'd0);
        step();
        cpu_stopped = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, REG_SP, 1'b1);
            check("abort_no_wr", 32'(reg_wr), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
        end

        // Random pin traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0)
                core_regs[$urandom_range(0, 3)] = 8'($urandom);
            apply_stimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                           1'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
